// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply/divide unit op encodings, FSM states and timing.
package mips_pkg;

    localparam int unsigned MDU_WIDTH   = 32;
    localparam int unsigned MDU_LATENCY = MDU_WIDTH + 1;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_CALC,
        MDU_FIX
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply or restoring divide on unsigned operands.
module mdu_iter_core #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               mode_div,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic [2*WIDTH-1:0] acc,
    output logic               is_div,
    output logic               last
);

    // Multiply: acc = {partial, multiplier}, opnd = multiplicand.
    // Divide:   acc = {remainder, dividend/quotient}, opnd = divisor.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic               div_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               ge;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = trial - {1'b0, opnd_q};
        ge      = ~diff[WIDTH];
        if (div_q) begin
            acc_d = {(ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (load) begin
            div_q  <= mode_div;
            acc_q  <= mode_div ? {{WIDTH{1'b0}}, opa} : {{WIDTH{1'b0}}, opb};
            opnd_q <= mode_div ? opb : opa;
            cnt_q  <= '0;
        end else if (step) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign acc    = acc_q;
    assign is_div = div_q;
    assign last   = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mips_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers; busy stalls dependent ops in EX.
module mips_mdu
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;
    logic               neg_q, rneg_q, div0_q;

    mdu_op_e            op_e;
    logic               is_md, op_signed, op_div, s1, s2;
    logic [WIDTH-1:0]   opa, opb;
    logic               load, step, last, is_div;
    logic [2*WIDTH-1:0] acc, prod;
    logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

    assign op_e = mdu_op_e'(op);

    always_comb begin
        is_md     = (op_e == MDU_MULT) || (op_e == MDU_MULTU) ||
                    (op_e == MDU_DIV)  || (op_e == MDU_DIVU);
        op_signed = (op_e == MDU_MULT) || (op_e == MDU_DIV);
        op_div    = (op_e == MDU_DIV)  || (op_e == MDU_DIVU);
        s1        = op_signed & data1[WIDTH-1];
        s2        = op_signed & data2[WIDTH-1];
        opa       = s1 ? -data1 : data1;
        opb       = s2 ? -data2 : data2;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (start && is_md) begin
                    load    = 1'b1;
                    state_d = MDU_CALC;
                end
            end
            MDU_CALC: begin
                step = 1'b1;
                if (last) state_d = MDU_FIX;
            end
            MDU_FIX:  state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
        if (flush) begin
            state_d = MDU_IDLE;
            load    = 1'b0;
            step    = 1'b0;
        end
    end

    mdu_iter_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .mode_div (op_div),
        .opa      (opa),
        .opb      (opb),
        .acc      (acc),
        .is_div   (is_div),
        .last     (last)
    );

    // Divide by zero keeps the all-ones quotient regardless of sign; the remainder
    // fix still restores the original dividend.
    always_comb begin
        prod   = neg_q ? -acc : acc;
        quot   = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        res_hi = prod[2*WIDTH-1:WIDTH];
        if (is_div) begin
            res_lo = div0_q ? '1 : (neg_q ? -quot : quot);
            res_hi = rneg_q ? -rem : rem;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (load) begin
                neg_q  <= s1 ^ s2;
                rneg_q <= s1;
                div0_q <= (data2 == '0);
            end
            if (!flush) begin
                if (state_q == MDU_FIX) begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end else if (state_q == MDU_IDLE && start) begin
                    if (op_e == MDU_MTHI) hi_q <= data1;
                    if (op_e == MDU_MTLO) lo_q <= data1;
                end
            end
        end
    end

    assign busy = (state_q != MDU_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_mdu.sv
// Directed scoreboard bench for mips_mdu: results queued at issue, checked on done.
module tb_mips_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data1, data2;
    logic        flush;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mips_mdu #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .data1 (data1),
        .data2 (data2),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive start for one cycle; returns at the sample point after the issuing edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        data1 = a;
        data2 = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'b111;
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input string tag);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Wait for done, counting busy cycles; pre = busy cycles already spent by the caller.
    task automatic wait_done(input int pre);
        int   n;
        bit   seen;
        exp_t e;
        n    = pre;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) n++;
            @(negedge clk);
        end
        chk("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("busy_cycles", 64'(n), 64'd33);
            chk("busy_low_at_done", 64'(busy), 64'd0);
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
                chk({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
            end
            @(negedge clk);
            chk("done_single_pulse", 64'(done), 64'd0);
        end
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'b111;
        data1 = '0;
        data2 = '0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        push(32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7");
        issue(3'b000, 32'hFFFF_FFFD, 32'd7);
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_done(0);

        push(32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0);

        push(32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2");
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done(0);

        push(32'h0000_0064, 32'hFFFF_FFFF, "divu_by0");
        issue(3'b011, 32'h0000_0064, 32'd0);
        wait_done(0);

        push(32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_m5_by0");
        issue(3'b010, 32'hFFFF_FFFB, 32'd0);
        wait_done(0);

        push(32'h0000_0000, 32'h8000_0000, "div_ovf");
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0);

        issue(3'b100, 32'h1234_5678, 32'd0);
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);
        issue(3'b101, 32'hCAFE_F00D, 32'd0);
        chk("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
        chk("mtlo_hi_kept", 64'(hi), 64'h1234_5678);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd0);

        // Flush alongside an IDLE start must swallow the start.
        flush = 1'b1;
        issue(3'b100, 32'hDEAD_BEEF, 32'd0);
        flush = 1'b0;
        chk("flush_start_hi", 64'(hi), 64'h1234_5678);
        chk("flush_start_busy", 64'(busy), 64'd0);

        // Second start at cycle 10 is ignored; operands must not be re-latched.
        push(32'd0, 32'd30, "mult_5x6_ignore2nd");
        issue(3'b000, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        chk("busy_at_2nd_start", 64'(busy), 64'd1);
        issue(3'b011, 32'd9, 32'd3);
        wait_done(10);

        // Flush at cycle 20.
        issue(3'b000, 32'd7, 32'd8);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hi", 64'(hi), 64'd0);
        chk("flush_lo", 64'(lo), 64'd30);
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("flush_no_done", 64'(pulses), 64'd0);
        chk("flush_lo_kept", 64'(lo), 64'd30);

        // Reset at cycle 15 of a DIV.
        issue(3'b010, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        push(32'd0, 32'd3, "divu_9d3_after_rst");
        issue(3'b011, 32'd9, 32'd3);
        wait_done(0);

        chk("sb_empty_at_end", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_mdu.md
Name: mips_mdu

Overview:
Iterative multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the single-cycle ALU in EX. It takes the MULT/MULTU/DIV/DIVU/MTHI/MTLO operations that the combinational ALU cannot complete in one cycle. It raises busy so the hazard unit stalls MFHI/MFLO and further MDU ops. It produces the HI/LO read values consumed on the EX-to-MEM result path.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even, 32 in the MIPS5 build.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  issue request; sampled only when busy=0
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others NOP
- data1  in  WIDTH  rs operand (multiplicand/dividend/MT source)
- data2  in  WIDTH  rt operand (multiplier/divisor)
- flush  in  1  abort in-flight op (branch/exception squash)
- busy  out  1  operation in progress; stall request to hazard unit
- done  out  1  one-cycle pulse when HI/LO committed by a mult/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0 at a rising edge): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Applies mid-operation; no partial result survives.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 with op=MTHI/MTLO: writes data1 into hi/lo at that edge; stays IDLE; busy and done remain 0.
  - start=1 with MULT/MULTU/DIV/DIVU: latches the operands. For signed ops, latches absolute values plus the result-sign bits (quotient sign = s1^s2, remainder sign = s1). Goes to CALC with counter=0 and busy=1.
  - NOP op codes are ignored.
- CALC:
  - One radix-2 step per cycle, WIDTH cycles in total.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder is WIDTH+1 bits wide.
  - Counter increments each cycle. On counter==WIDTH-1 the FSM moves to FIX.
- FIX:
  - Applies two's-complement sign correction.
  - Multiply: {hi,lo} = product.
  - Divide: lo = quotient, hi = remainder.
  - Commits hi/lo, pulses done=1 for exactly this cycle, drops busy, returns to IDLE.
- Latency: start sampled at edge E0 → busy=1 after E0 → new hi/lo and done=1 visible after edge E(WIDTH+1), i.e. 33 cycles for WIDTH=32. busy is low in the cycle done is high.
- start while busy=1: ignored; no queueing, operands are not re-latched.
- flush=1 (any state): returns to IDLE at that edge; busy=0; hi/lo unchanged; no done pulse.
  - Flush takes priority over a FIX commit in the same cycle.
  - Flush with start=1 in IDLE: start is ignored.
- Divide by zero (data2=0, signed or unsigned): no trap. After full latency, hi=data1 (original, unsigned-as-given), lo={WIDTH{1}}.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap; no exception).
- Unsigned ops: no sign handling; the FIX stage passes values through.
- hi/lo are registered outputs only. There is no combinational path from inputs to any output.

Decomposition:
- Shared package mips_pkg (extend the existing one):
  - MDU op encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - State enum: MDU_IDLE, MDU_CALC, MDU_FIX.
  - Constant MDU_LATENCY = WIDTH+1.
- One sub-module: mdu_iter_core.
  - Contains the shift-add / shift-subtract datapath and the iteration counter.
  - Driven by load/step/mode signals from mips_mdu's FSM.
  - The FSM, sign fix and HI/LO registers stay in mips_mdu.

Test Plan:
- MULT data1=0xFFFFFFFD (−3), data2=7 → busy high for 33 cycles, single done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x64 / 0 → hi=0x00000064, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678 then MTLO 0xCAFEF00D → hi/lo updated one edge after each start; busy and done never assert.
- MULT 5×6 started, second start (DIVU 9/3) at cycle 10 → ignored; result hi=0, lo=30. Flush at cycle 20 of another MULT → busy=0 next cycle, hi/lo keep 0/30, no done pulse.
- rst_n=0 for one edge at cycle 15 of a DIV → hi=lo=0, busy=0. A DIVU 9/3 issued afterwards completes normally with lo=3, hi=0.
